// File: rtl/crc_lane_feeder.sv
// Feeds one message word per frame to the parallel CRC stage, MSB-first as LANES-bit groups,
// followed by zero pad groups, with first/last markers for the CRC to clear and latch its state.
module crc_lane_feeder #(
    parameter int MSG_W = 9,
    parameter int LANES = 3,
    parameter int PAD_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [MSG_W-1:0] msg_in,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic             lane_hold,
    output logic [LANES-1:0] lane_out,
    output logic             lane_valid,
    output logic             lane_first,
    output logic             lane_last
);

    localparam int MB = MSG_W / LANES;
    localparam int PB = PAD_W / LANES;
    localparam int TB = MB + PB;
    localparam int CW = (TB + 1 > 2) ? $clog2(TB + 1) : 1;

    localparam logic [CW-1:0] MB_C      = CW'(MB);
    localparam logic [CW-1:0] LAST_C    = CW'(TB - 1);
    localparam logic [CW-1:0] CNT_ONE_C = CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [MSG_W-1:0] sr_r;
    logic [MSG_W-1:0] sr_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_s;
    logic             last_beat_s;

    // Output decode: lane outputs come only from registered state; msg_ready also sees lane_hold.
    always_comb begin
        msg_ready   = 1'b0;
        lane_valid  = 1'b0;
        lane_first  = 1'b0;
        lane_last   = 1'b0;
        lane_out    = {LANES{1'b0}};
        last_beat_s = (cnt_r == LAST_C);
        case (state_r)
            IDLE: begin
                msg_ready = 1'b1;
            end
            SEND: begin
                lane_valid = 1'b1;
                lane_first = (cnt_r == {CW{1'b0}});
                lane_last  = last_beat_s;
                msg_ready  = last_beat_s & ~lane_hold;
                if (cnt_r < MB_C) begin
                    lane_out = sr_r[MSG_W-1 -: LANES];
                end else begin
                    lane_out = {LANES{1'b0}};
                end
            end
            default: begin
                msg_ready = 1'b0;
            end
        endcase
    end

    // Next-state logic: load on accept, shift one group per unheld beat, reload on the last beat.
    always_comb begin
        state_s = state_r;
        sr_s    = sr_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (msg_valid) begin
                    state_s = SEND;
                    sr_s    = msg_in;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (lane_hold) begin
                    state_s = SEND;
                end else if (last_beat_s) begin
                    if (msg_valid) begin
                        state_s = SEND;
                        sr_s    = msg_in;
                        cnt_s   = {CW{1'b0}};
                    end else begin
                        state_s = IDLE;
                        sr_s    = sr_r << LANES;
                        cnt_s   = cnt_r + CNT_ONE_C;
                    end
                end else begin
                    state_s = SEND;
                    sr_s    = sr_r << LANES;
                    cnt_s   = cnt_r + CNT_ONE_C;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over any accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            sr_r    <= {MSG_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_s;
            sr_r    <= sr_s;
            cnt_r   <= cnt_s;
        end
    end

endmodule
